// File: rtl/clk_ratio_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_ratio_pkg
// Purpose  : Shared constants for the clock-ratio meter: FSM state encoding
//            and the default counter width / stall timeout.
// Ports    : none (package)
// Macro    : CLK_RATIO_META_SYNC_EN (consumed by edge_sampler / clk_ratio_meter)
// Revision : 1.0 - initial release
// ============================================================================
package clk_ratio_pkg;

    // Measurement FSM encoding.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_STALLED = 2'd2;

    // Defaults shared by the interface and the top module.
    localparam int c_CNT_W_DEFAULT   = 28;
    localparam int c_TIMEOUT_DEFAULT = 1024;

endpackage : clk_ratio_pkg
`default_nettype wire

// File: rtl/clk_ratio_meter_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_ratio_meter_if
// Purpose  : Bundle of the measured divided clock and the meter's status /
//            measurement outputs.
// Signals  : div_clock_in  - divided clock under measurement (sampled as data)
//            period_out    - last measured period in clock_in cycles
//            high_out      - high cycles within the last measured period
//            meas_valid    - one-cycle pulse when period_out/high_out update
//            div_match     - period_out equals the expected divisor
//            locked        - stable-period indicator
//            stalled       - no rising edge within the timeout
// Modports : master - drives div_clock_in, observes the results
//            slave  - the meter itself
// Revision : 1.0 - initial release
// ============================================================================
interface clk_ratio_meter_if
    import clk_ratio_pkg::*;
#(
    parameter int CNT_W = c_CNT_W_DEFAULT
);
    logic             div_clock_in;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             meas_valid;
    logic             div_match;
    logic             locked;
    logic             stalled;

    modport master (
        output div_clock_in,
        input  period_out,
        input  high_out,
        input  meas_valid,
        input  div_match,
        input  locked,
        input  stalled
    );

    modport slave (
        input  div_clock_in,
        output period_out,
        output high_out,
        output meas_valid,
        output div_match,
        output locked,
        output stalled
    );
endinterface : clk_ratio_meter_if
`default_nettype wire

// File: rtl/clk_ratio_meter_edge_sampler.sv
`default_nettype none
// ============================================================================
// Module   : edge_sampler
// Purpose  : Samples the divided clock as data and produces the current
//            sample and a one-cycle rising-edge pulse.
// Ports    : clock_in       - block clock
//            reset          - synchronous active-high reset
//            i_div_clock    - divided clock under measurement
//            o_s_cur        - registered sample of the divided clock
//            o_rise         - high for one cycle when the sample goes 0 -> 1
// Macro    : CLK_RATIO_META_SYNC_EN - inserts a 2-flop synchronizer ahead of
//            the sample register (adds 2 cycles of latency).
// Revision : 1.0 - initial release
// ============================================================================
module edge_sampler (
    input  wire logic clock_in,
    input  wire logic reset,
    input  wire logic i_div_clock,
    output logic      o_s_cur,
    output logic      o_rise
);

    logic w_sample_d;
    logic r_s_cur;
    logic r_s_prev;

`ifdef CLK_RATIO_META_SYNC_EN
    // Input may be asynchronous to clock_in: resolve metastability first.
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_div_clock;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample_d = r_sync2;
`else
    assign w_sample_d = i_div_clock;
`endif

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_s_cur  <= 1'b0;
            r_s_prev <= 1'b0;
        end else begin
            r_s_cur  <= w_sample_d;
            r_s_prev <= r_s_cur;
        end
    end

    assign o_s_cur = r_s_cur;
    assign o_rise  = r_s_cur & ~r_s_prev;

endmodule : edge_sampler
`default_nettype wire

// File: rtl/clk_ratio_meter.sv
`default_nettype none
// ============================================================================
// Module   : clk_ratio_meter
// Purpose  : Cycle-accurate monitor for a divided clock generated in the
//            clock_in domain. Measures period (rise to rise) and high time,
//            and flags divisor match, lock and stall.
// Ports    : clock_in  - block clock (same clock as the divider)
//            reset     - synchronous active-high reset
//            mon       - clk_ratio_meter_if.slave: div_clock_in in;
//                        period_out, high_out, meas_valid, div_match,
//                        locked, stalled out
// Params   : CNT_W, EXP_DIVISOR, LOCK_COUNT (1..15), TIMEOUT (> EXP_DIVISOR)
// Macro    : CLK_RATIO_META_SYNC_EN - input synchronizer and +/-1 cycle
//            period tolerance in the lock comparison.
// Revision : 1.0 - initial release
// ============================================================================
module clk_ratio_meter
    import clk_ratio_pkg::*;
#(
    parameter int               CNT_W       = c_CNT_W_DEFAULT,
    parameter logic [CNT_W-1:0] EXP_DIVISOR = CNT_W'(8),
    parameter int               LOCK_COUNT  = 3,
    parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(c_TIMEOUT_DEFAULT)
) (
    input  wire logic        clock_in,
    input  wire logic        reset,
    clk_ratio_meter_if.slave mon
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [3:0]       c_LOCK    = 4'(LOCK_COUNT);

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic w_s_cur;
    logic w_rise;

    edge_sampler u_edge_sampler (
        .clock_in    (clock_in),
        .reset       (reset),
        .i_div_clock (mon.div_clock_in),
        .o_s_cur     (w_s_cur),
        .o_rise      (w_rise)
    );

    // ------------------------------------------------------------------
    // Run / high counters. Both reload to 1 on the rise cycle, so at the
    // next rise they hold exactly the cycles of the completed period.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_run_cnt;
    logic [CNT_W-1:0] r_hi_cnt;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_run_cnt <= '0;
            r_hi_cnt  <= '0;
        end else begin
            if (w_rise) begin
                r_run_cnt <= c_CNT_ONE;
            end else if (r_run_cnt != c_CNT_MAX) begin
                r_run_cnt <= r_run_cnt + c_CNT_ONE;
            end

            if (w_rise) begin
                r_hi_cnt <= c_CNT_ONE;
            end else if (w_s_cur && (r_hi_cnt != c_CNT_MAX)) begin
                r_hi_cnt <= r_hi_cnt + c_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       w_take_meas;
    logic       w_enter_stall;
    logic       w_stalled;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_next = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                // A rise in the timeout cycle still counts as a period.
                if (!w_rise && (r_run_cnt == TIMEOUT)) begin
                    w_state_next = ST_STALLED;
                end
            end
            ST_STALLED: begin
                if (w_rise) begin
                    w_state_next = ST_MEASURE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_take_meas   = 1'b0;
        w_enter_stall = 1'b0;
        w_stalled     = 1'b0;
        case (r_state)
            ST_MEASURE: begin
                w_take_meas   = w_rise;
                w_enter_stall = !w_rise && (r_run_cnt == TIMEOUT);
            end
            ST_STALLED: begin
                w_stalled = 1'b1;
            end
            default: begin
                w_take_meas = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Lock comparison against the previous period
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_prev_period;
    logic             r_prev_valid;
    logic [3:0]       r_match_cnt;
    logic [3:0]       w_match_next;
    logic             w_same;

`ifdef CLK_RATIO_META_SYNC_EN
    logic [CNT_W-1:0] w_diff;

    // Synchronizer phase can move an edge by one cycle: tolerate +/-1.
    always_comb begin
        if (r_run_cnt >= r_prev_period) begin
            w_diff = r_run_cnt - r_prev_period;
        end else begin
            w_diff = r_prev_period - r_run_cnt;
        end
        w_same = (w_diff <= c_CNT_ONE);
    end
`else
    always_comb begin
        w_same = (r_run_cnt == r_prev_period);
    end
`endif

    always_comb begin
        w_match_next = '0;
        if (r_prev_valid && w_same) begin
            if (r_match_cnt == c_LOCK) begin
                w_match_next = r_match_cnt;
            end else begin
                w_match_next = r_match_cnt + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Measurement / status registers
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_meas_valid;
    logic             r_div_match;
    logic             r_locked;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_period      <= '0;
            r_high        <= '0;
            r_meas_valid  <= 1'b0;
            r_div_match   <= 1'b0;
            r_locked      <= 1'b0;
            r_match_cnt   <= '0;
            r_prev_period <= '0;
            r_prev_valid  <= 1'b0;
        end else begin
            r_meas_valid <= w_take_meas;
            if (w_take_meas) begin
                r_period      <= r_run_cnt;
                r_high        <= r_hi_cnt;
                r_div_match   <= (r_run_cnt == EXP_DIVISOR);
                r_match_cnt   <= w_match_next;
                r_locked      <= (w_match_next == c_LOCK);
                r_prev_period <= r_run_cnt;
                r_prev_valid  <= 1'b1;
            end else if (w_enter_stall) begin
                // Restart lock qualification from scratch after a stall;
                // measured values are kept for debug visibility.
                r_match_cnt  <= '0;
                r_locked     <= 1'b0;
                r_prev_valid <= 1'b0;
            end
        end
    end

    assign mon.period_out = r_period;
    assign mon.high_out   = r_high;
    assign mon.meas_valid = r_meas_valid;
    assign mon.div_match  = r_div_match;
    assign mon.locked     = r_locked;
    assign mon.stalled    = w_stalled;

endmodule : clk_ratio_meter
`default_nettype wire

// File: tb/tb_clk_ratio_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_ratio_meter
// Purpose  : Self-checking bench for clk_ratio_meter. A timestamp-based model
//            derives period/high/lock/stall from the sampled input history and
//            is compared against the DUT every cycle; directed phases add
//            hand-computed literal expectations.
// Macro    : CLK_RATIO_META_SYNC_EN - adjusts latency and lock tolerance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_ratio_meter;
    import clk_ratio_pkg::*;

    localparam int               CNT_W = 28;
    localparam logic [CNT_W-1:0] EXPD  = 28'd8;
    localparam int               LOCKN = 3;
    localparam int               TMO   = 32;
`ifdef CLK_RATIO_META_SYNC_EN
    localparam int LAT = 2;
    localparam int TOL = 1;
`else
    localparam int LAT = 0;
    localparam int TOL = 0;
`endif
    localparam int MAXC = 4096;

    logic clock_in = 1'b0;
    logic reset    = 1'b1;

    clk_ratio_meter_if #(.CNT_W(CNT_W)) bus ();

    clk_ratio_meter #(
        .CNT_W       (CNT_W),
        .EXP_DIVISOR (EXPD),
        .LOCK_COUNT  (LOCKN),
        .TIMEOUT     (CNT_W'(TMO))
    ) dut (
        .clock_in (clock_in),
        .reset    (reset),
        .mon      (bus)
    );

    always #5 clock_in = ~clock_in;

    // ------------------------------------------------------------------
    // Input / reset history as seen at each rising edge
    // ------------------------------------------------------------------
    bit in_hist  [MAXC];
    bit rst_hist [MAXC];
    int cyc      = 0;
    int last_rst = -1000;

    always @(posedge clock_in) begin
        if (cyc < MAXC) begin
            in_hist[cyc]  = bus.div_clock_in;
            rst_hist[cyc] = reset;
        end
        cyc = cyc + 1;
    end

    // Value the meter "sees" as its current sample during cycle c.
    function automatic bit s_at(int c);
        if ((c - LAT) < 0 || (c - LAT) <= last_rst) return 1'b0;
        return in_hist[c - LAT];
    endfunction

    // ------------------------------------------------------------------
    // Counters and check helper
    // ------------------------------------------------------------------
    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(string name, longint act, longint exp);
        vectors = vectors + 1;
        if (act != exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: timestamps of rises, window sums for high time
    // ------------------------------------------------------------------
    bit m_run   = 0;   // a reference rise exists and we are timing a period
    bit m_stall = 0;
    int m_last  = 0;
    bit m_pv    = 0;
    int m_prev  = 0;
    int m_mc    = 0;
    int e_period = 0, e_high = 0;
    bit e_mv = 0, e_dm = 0, e_lk = 0, e_st = 0;

    task automatic model_reset();
        m_run = 0; m_stall = 0; m_pv = 0; m_mc = 0; m_prev = 0;
        e_period = 0; e_high = 0; e_mv = 0; e_dm = 0; e_lk = 0; e_st = 0;
    endtask

    task automatic model_step(int c);
        bit r;
        int p, h, d;
        r = s_at(c) && !s_at(c - 1);
        e_mv = 0;
        if (m_stall) begin
            if (r) begin m_stall = 0; e_st = 0; m_run = 1; m_last = c; end
        end else if (!m_run) begin
            if (r) begin m_run = 1; m_last = c; end
        end else if (r) begin
            p = c - m_last;
            h = 0;
            for (int k = m_last; k < c; k++) h += int'(s_at(k));
            d = (p > m_prev) ? p - m_prev : m_prev - p;
            if (m_pv && d <= TOL) m_mc = (m_mc < LOCKN) ? m_mc + 1 : LOCKN;
            else                  m_mc = 0;
            m_prev = p; m_pv = 1;
            e_period = p; e_high = h; e_mv = 1; e_dm = (p == int'(EXPD));
            e_lk = (m_mc == LOCKN);
            m_last = c;
        end else if (c - m_last == TMO) begin
            m_run = 0; m_stall = 1; e_st = 1; e_lk = 0; m_pv = 0; m_mc = 0;
        end
    endtask

    // ------------------------------------------------------------------
    // Compare process + event logging
    // ------------------------------------------------------------------
    typedef struct {
        int cyc;
        int period;
        int high;
        bit dm;
        bit lk;
    } meas_t;

    meas_t mq[$];
    int    stall_first = -1;
    bit    prev_st     = 0;

    always @(negedge clock_in) begin
        int c;
        c = cyc - 1;
        if (c >= 0 && c < MAXC) begin
            if (rst_hist[c]) begin
                last_rst = c;
                model_reset();
            end
            chk("period_out", bus.period_out, e_period);
            chk("high_out",   bus.high_out,   e_high);
            chk("meas_valid", bus.meas_valid, e_mv);
            chk("div_match",  bus.div_match,  e_dm);
            chk("locked",     bus.locked,     e_lk);
            chk("stalled",    bus.stalled,    e_st);
            if (bus.meas_valid)
                mq.push_back('{c, int'(bus.period_out), int'(bus.high_out),
                               bus.div_match, bus.locked});
            if (bus.stalled && !prev_st && stall_first < 0) stall_first = c;
            prev_st = bus.stalled;
            if (!rst_hist[c]) model_step(c);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    int drv_rise[$];
    bit drv_last = 0;

    task automatic drive(bit v);
        @(negedge clock_in);
        if (v && !drv_last) drv_rise.push_back(cyc);  // edge that samples it
        bus.div_clock_in = v;
        drv_last = v;
    endtask

    task automatic periods(int hi, int lo, int n);
        for (int i = 0; i < n; i++) begin
            repeat (hi) drive(1'b1);
            repeat (lo) drive(1'b0);
        end
    endtask

    task automatic chk_meas(string name, int idx, int period, int high, int dm, int lk);
        if (idx >= mq.size()) begin
            chk({name, "_present"}, mq.size(), idx + 1);
        end else begin
            chk({name, "_period"}, mq[idx].period, period);
            if (high >= 0) chk({name, "_high"}, mq[idx].high, high);
            if (dm >= 0)   chk({name, "_dm"},   mq[idx].dm,   dm);
            if (lk >= 0)   chk({name, "_lk"},   mq[idx].lk,   lk);
        end
    endtask

    initial begin
        #(30000 * 10);
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed phases
    // ------------------------------------------------------------------
    initial begin
        int base;
        int rise_e;
        bus.div_clock_in = 1'b0;
        repeat (3) drive(1'b0);
        chk("rst_period", bus.period_out, 0);
        chk("rst_stalled", bus.stalled, 0);
        reset = 1'b0;
        repeat (2) drive(1'b0);

        // Steady divide-by-8
        periods(4, 4, 8);
        chk("b_count", mq.size(), 7);
        chk_meas("b_first", 0, 8, 4, 1, 0);
        chk_meas("b_third", 2, 8, 4, 1, 0);
        chk_meas("b_fourth", 3, 8, 4, 1, 1);
        if (mq.size() > 0) chk("b_latency", mq[0].cyc, drv_rise[1] + LAT + 1);

        // Switch to period 6 while locked
        base = mq.size();
        periods(3, 3, 6);
        chk_meas("c_tail8", base, 8, 4, 1, 1);
        chk_meas("c_first6", base + 1, 6, 3, 0, 0);
        chk_meas("c_third6", base + 3, 6, 3, 0, 0);
        chk_meas("c_relock", base + 4, 6, 3, 0, 1);

        // Asymmetric 3 high / 7 low
        base = mq.size();
        periods(3, 7, 4);
        chk_meas("d_tail6", base, 6, 3, 0, -1);
        chk_meas("d_first10", base + 1, 10, 3, 0, 0);

        // Stall: one rise then hold low
        base = mq.size();
        stall_first = -1;
        repeat (3) drive(1'b1);
        rise_e = drv_rise[$];
        repeat (60) drive(1'b0);
        chk_meas("e_pre_stall", base, 10, 3, 0, 1);
        chk("e_stall_cycle", stall_first, rise_e + LAT + TMO + 1);
        chk("e_stalled", bus.stalled, 1);
        chk("e_locked", bus.locked, 0);
        chk("e_period_hold", bus.period_out, 10);
        periods(4, 4, 1);
        chk("e_restart_nomeas", mq.size(), base + 1);
        chk("e_unstalled", bus.stalled, 0);
        periods(4, 4, 2);
        chk_meas("e_post", base + 1, 8, 4, 1, 0);

        // Lock, then reset mid-period (low portion)
        periods(4, 4, 6);
        repeat (4) drive(1'b1);
        drive(1'b0);
        chk("f_locked_pre", bus.locked, 1);
        reset = 1'b1;
        drive(1'b0);
        reset = 1'b0;
        drive(1'b0);
        chk("f_rst_period", bus.period_out, 0);
        chk("f_rst_locked", bus.locked, 0);
        chk("f_rst_match", bus.div_match, 0);
        base = mq.size();
        drive(1'b0);
        periods(4, 4, 1);
        chk("f_first_nomeas", mq.size(), base);
        periods(4, 4, 2);
        chk_meas("f_post", base, 8, 4, 1, 0);

        // Alternating 8 / 9 periods: locks only with +/-1 tolerance
        for (int i = 0; i < 6; i++) begin
            periods(4, 4, 1);
            periods(4, 5, 1);
        end
        chk("g_alt_locked", bus.locked, TOL);

        repeat (4) drive(1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_clk_ratio_meter
`default_nettype wire
